// File: rtl/bw_monitor_mc_if.sv
// Observation bundle for the monitored stream/AXI channels: one qualified-beat
// bit and one last-marker bit per channel.
interface bw_monitor_mc_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0] beat;
  logic [NUM_CH-1:0] last;

  modport master (output beat, output last);
  modport slave  (input  beat, input  last);
endinterface

// File: rtl/bw_monitor_mc.sv
// Multi-channel bandwidth monitor: counts beats and bursts per channel inside a
// software-controlled window and exposes one channel at a time on a read port.
module bw_monitor_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int TS_W       = 32,
  parameter int LAST_EDGE  = 1,
  parameter int ARM_ON_ACT = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  bw_monitor_mc_if.slave    mon,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [TS_W-1:0]   i_window_len,
  input  logic [CH_W-1:0]   i_chan_sel,
  output logic [1:0]        o_state,
  output logic              o_busy,
  output logic [TS_W-1:0]   o_timer,
  output logic              o_timer_ovf,
  output logic [CNT_W-1:0]  o_rd_beat_cnt,
  output logic [CNT_W-1:0]  o_rd_burst_cnt,
  output logic [TS_W-1:0]   o_rd_first_ts,
  output logic [TS_W-1:0]   o_rd_last_ts,
  output logic [2:0]        o_rd_flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [TS_W-1:0]  TS_MAX   = {TS_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_clear;
  logic              w_count;
  logic              w_timer_inc;
  logic              w_win_end;
  logic              w_any_beat;
  logic [NUM_CH-1:0] w_burst_ev;

  logic [TS_W-1:0]   r_timer;
  logic              r_timer_ovf;
  logic              r_busy;
  logic [NUM_CH-1:0] r_last_d;
  logic [NUM_CH-1:0] r_seen;
  logic [NUM_CH-1:0] r_beat_sat;
  logic [NUM_CH-1:0] r_burst_sat;
  logic [CNT_W-1:0]  r_beat_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_burst_cnt [NUM_CH];
  logic [TS_W-1:0]   r_first_ts  [NUM_CH];
  logic [TS_W-1:0]   r_last_ts   [NUM_CH];

  assign w_any_beat = |mon.beat;
  assign w_win_end  = (i_window_len != {TS_W{1'b0}}) &&
                      (r_timer == (i_window_len - {{(TS_W-1){1'b0}}, 1'b1}));
  assign w_burst_ev = (LAST_EDGE != 0) ? (mon.last & ~r_last_d) : (mon.beat & mon.last);

  // Window state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start clears everywhere except RUN, and stop beats start in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_ARMED;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_ARMED: begin
        if (i_start) begin
          w_state_nxt = S_ARMED;
          w_clear     = 1'b1;
        end else if (ARM_ON_ACT == 0) begin
          w_state_nxt = S_RUN;
        end else if (w_any_beat) begin
          w_state_nxt = S_RUN;
          w_count     = 1'b1;
        end else begin
          w_state_nxt = S_ARMED;
        end
      end
      S_RUN: begin
        w_count = 1'b1;
        if (i_stop || w_win_end) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_timer_inc = (r_state == S_RUN) && (w_state_nxt == S_RUN);
  end

  // Window timer with sticky saturation flag, plus registered busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= {TS_W{1'b0}};
      r_timer_ovf <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_RUN);
      if (w_clear) begin
        r_timer     <= {TS_W{1'b0}};
        r_timer_ovf <= 1'b0;
      end else if (w_timer_inc) begin
        if (r_timer == TS_MAX) begin
          r_timer_ovf <= 1'b1;
        end else begin
          r_timer <= r_timer + {{(TS_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Last-marker history for edge detection, tracked in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= {NUM_CH{1'b0}};
    end else begin
      r_last_d <= mon.last;
    end
  end

  // Per-channel statistics
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_seen      <= {NUM_CH{1'b0}};
      r_beat_sat  <= {NUM_CH{1'b0}};
      r_burst_sat <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        r_beat_cnt[i]  <= {CNT_W{1'b0}};
        r_burst_cnt[i] <= {CNT_W{1'b0}};
        r_first_ts[i]  <= {TS_W{1'b0}};
        r_last_ts[i]   <= {TS_W{1'b0}};
      end
    end else if (w_count) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mon.beat[i]) begin
          if (r_beat_cnt[i] == CNT_MAX) begin
            r_beat_sat[i] <= 1'b1;
          end else begin
            r_beat_cnt[i] <= r_beat_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (!r_seen[i]) begin
            r_seen[i]     <= 1'b1;
            r_first_ts[i] <= r_timer;
          end
        end
        if (w_burst_ev[i]) begin
          r_last_ts[i] <= r_timer;
          if (r_burst_cnt[i] == CNT_MAX) begin
            r_burst_sat[i] <= 1'b1;
          end else begin
            r_burst_cnt[i] <= r_burst_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  // Registered channel-select read port; unused selector codes read as zero
  always_ff @(posedge clk) begin
    if (rst || ({1'b0, i_chan_sel} >= NUM_CH_V)) begin
      o_rd_beat_cnt  <= {CNT_W{1'b0}};
      o_rd_burst_cnt <= {CNT_W{1'b0}};
      o_rd_first_ts  <= {TS_W{1'b0}};
      o_rd_last_ts   <= {TS_W{1'b0}};
      o_rd_flags     <= 3'b000;
    end else begin
      o_rd_beat_cnt  <= r_beat_cnt[i_chan_sel];
      o_rd_burst_cnt <= r_burst_cnt[i_chan_sel];
      o_rd_first_ts  <= r_first_ts[i_chan_sel];
      o_rd_last_ts   <= r_last_ts[i_chan_sel];
      o_rd_flags     <= {r_seen[i_chan_sel], r_burst_sat[i_chan_sel], r_beat_sat[i_chan_sel]};
    end
  end

  assign o_state     = r_state;
  assign o_busy      = r_busy;
  assign o_timer     = r_timer;
  assign o_timer_ovf = r_timer_ovf;

endmodule

// File: tb/tb_bw_monitor_mc.sv
// Directed bench: instance A (4 ch, 8-bit counters/timer, edge bursts, immediate run)
// and instance B (3 ch, 16-bit, per-beat bursts, arm-on-activity).
module tb_bw_monitor_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A
  logic       a_rst, a_start, a_stop;
  logic [7:0] a_wlen;
  logic [1:0] a_sel;
  logic [1:0] a_state;
  logic       a_busy, a_ovf;
  logic [7:0] a_timer, a_rbeat, a_rburst, a_rfirst, a_rlast;
  logic [2:0] a_flags;
  bw_monitor_mc_if #(.NUM_CH(4)) if_a ();

  bw_monitor_mc #(.NUM_CH(4), .CNT_W(8), .TS_W(8), .LAST_EDGE(1), .ARM_ON_ACT(0)) u_a (
    .clk(clk), .rst(a_rst), .mon(if_a), .i_start(a_start), .i_stop(a_stop),
    .i_window_len(a_wlen), .i_chan_sel(a_sel), .o_state(a_state), .o_busy(a_busy),
    .o_timer(a_timer), .o_timer_ovf(a_ovf), .o_rd_beat_cnt(a_rbeat),
    .o_rd_burst_cnt(a_rburst), .o_rd_first_ts(a_rfirst), .o_rd_last_ts(a_rlast),
    .o_rd_flags(a_flags)
  );

  // DUT B
  logic        b_rst, b_start, b_stop;
  logic [15:0] b_wlen;
  logic [1:0]  b_sel;
  logic [1:0]  b_state;
  logic        b_busy, b_ovf;
  logic [15:0] b_timer, b_rbeat, b_rburst, b_rfirst, b_rlast;
  logic [2:0]  b_flags;
  bw_monitor_mc_if #(.NUM_CH(3)) if_b ();

  bw_monitor_mc #(.NUM_CH(3), .CNT_W(16), .TS_W(16), .LAST_EDGE(0), .ARM_ON_ACT(1)) u_b (
    .clk(clk), .rst(b_rst), .mon(if_b), .i_start(b_start), .i_stop(b_stop),
    .i_window_len(b_wlen), .i_chan_sel(b_sel), .o_state(b_state), .o_busy(b_busy),
    .o_timer(b_timer), .o_timer_ovf(b_ovf), .o_rd_beat_cnt(b_rbeat),
    .o_rd_burst_cnt(b_rburst), .o_rd_first_ts(b_rfirst), .o_rd_last_ts(b_rlast),
    .o_rd_flags(b_flags)
  );

  typedef struct {
    logic       start;
    logic [3:0] beat;
    logic [3:0] last;
    logic [1:0] exp_state;
    logic [7:0] exp_timer;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    // window_len=10, beat[0] every RUN cycle, last[0] on 4th and 8th beat
    vt[0]  = '{1'b1, 4'h0, 4'h0, 2'd1, 8'd0};
    vt[1]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd0};
    vt[2]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd1};
    vt[3]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd2};
    vt[4]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd3};
    vt[5]  = '{1'b0, 4'h1, 4'h1, 2'd2, 8'd4};
    vt[6]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd5};
    vt[7]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd6};
    vt[8]  = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd7};
    vt[9]  = '{1'b0, 4'h1, 4'h1, 2'd2, 8'd8};
    vt[10] = '{1'b0, 4'h1, 4'h0, 2'd2, 8'd9};
    vt[11] = '{1'b0, 4'h1, 4'h0, 2'd3, 8'd9};
    vt[12] = '{1'b0, 4'h1, 4'h1, 2'd3, 8'd9};

    a_rst = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_wlen = 8'd10; a_sel = 2'd0;
    if_a.beat = 4'h0; if_a.last = 4'h0;
    b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_wlen = 16'd0; b_sel = 2'd0;
    if_b.beat = 3'h0; if_b.last = 3'h0;
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    chk("a_reset_state", 32'(a_state), 32'd0);
    chk("a_reset_timer", 32'(a_timer), 32'd0);
    chk("a_reset_busy",  32'(a_busy),  32'd0);
    chk("a_reset_rbeat", 32'(a_rbeat), 32'd0);
    chk("b_reset_state", 32'(b_state), 32'd0);

    // Table-driven bounded window
    for (int i = 0; i < 13; i++) begin
      a_start = vt[i].start; if_a.beat = vt[i].beat; if_a.last = vt[i].last;
      tick();
      chk($sformatf("win_state[%0d]", i), 32'(a_state), 32'(vt[i].exp_state));
      chk($sformatf("win_timer[%0d]", i), 32'(a_timer), 32'(vt[i].exp_timer));
    end
    a_start = 1'b0; if_a.beat = 4'h0; if_a.last = 4'h0; a_sel = 2'd0;
    tick();
    chk("win_ch0_beat",  32'(a_rbeat),  32'd10);
    chk("win_ch0_burst", 32'(a_rburst), 32'd2);
    chk("win_ch0_first", 32'(a_rfirst), 32'd0);
    chk("win_ch0_last",  32'(a_rlast),  32'd7);
    chk("win_ch0_flags", 32'(a_flags),  32'b100);
    chk("win_done_busy", 32'(a_busy),   32'd0);

    // Rising-edge burst: last[1] high for 3 beats counts once
    a_wlen = 8'd0; a_start = 1'b1; tick(); a_start = 1'b0;
    chk("edge_armed_busy", 32'(a_busy), 32'd1);
    tick();
    chk("edge_run_state", 32'(a_state), 32'd2);
    if_a.beat = 4'h2; if_a.last = 4'h2;
    repeat (3) tick();
    if_a.beat = 4'h0; if_a.last = 4'h0; a_sel = 2'd1;
    tick(); tick();
    chk("edge_ch1_burst", 32'(a_rburst), 32'd1);
    chk("edge_ch1_beat",  32'(a_rbeat),  32'd3);
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    chk("edge_stop_state", 32'(a_state), 32'd3);

    // Beat counter and timer saturation, then freeze in DONE
    a_start = 1'b1; tick(); a_start = 1'b0;
    if_a.beat = 4'h8;
    tick();
    repeat (300) tick();
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    a_sel = 2'd3;
    repeat (5) tick();
    chk("sat_state", 32'(a_state),  32'd3);
    chk("sat_beat",  32'(a_rbeat),  32'd255);
    chk("sat_burst", 32'(a_rburst), 32'd0);
    chk("sat_first", 32'(a_rfirst), 32'd0);
    chk("sat_flags", 32'(a_flags),  32'b101);
    chk("sat_timer", 32'(a_timer),  32'd255);
    chk("sat_ovf",   32'(a_ovf),    32'd1);

    // start from DONE clears everything
    if_a.beat = 4'h0; a_start = 1'b1; tick(); a_start = 1'b0;
    chk("restart_state", 32'(a_state), 32'd1);
    chk("restart_timer", 32'(a_timer), 32'd0);
    chk("restart_ovf",   32'(a_ovf),   32'd0);
    tick();
    chk("restart_beat",  32'(a_rbeat), 32'd0);
    chk("restart_flags", 32'(a_flags), 32'd0);

    // Reset mid-RUN with live counts
    if_a.beat = 4'h1; a_sel = 2'd0;
    repeat (4) tick();
    if_a.beat = 4'h0;
    tick();
    chk("pre_rst_beat", 32'(a_rbeat), 32'd4);
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_timer", 32'(a_timer), 32'd0);
    chk("rst_beat",  32'(a_rbeat), 32'd0);
    chk("rst_flags", 32'(a_flags), 32'd0);

    // Arm-on-activity: waits in ARMED, first beat enters RUN and is counted
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (5) tick();
    chk("arm_wait_state", 32'(b_state), 32'd1);
    if_b.beat = 3'h4; tick(); if_b.beat = 3'h0;
    chk("arm_run_state", 32'(b_state), 32'd2);
    b_sel = 2'd2; tick();
    chk("arm_ch2_beat",  32'(b_rbeat),  32'd1);
    chk("arm_ch2_first", 32'(b_rfirst), 32'd0);
    chk("arm_ch2_flags", 32'(b_flags),  32'b100);
    b_sel = 2'd0; tick();
    chk("arm_ch0_beat",  32'(b_rbeat),  32'd0);
    chk("arm_ch0_flags", 32'(b_flags),  32'd0);

    // Per-beat bursts: last[1] held 3 beats counts 3
    if_b.beat = 3'h2; if_b.last = 3'h2;
    repeat (3) tick();
    if_b.beat = 3'h0; if_b.last = 3'h0; b_sel = 2'd1;
    tick(); tick();
    chk("lvl_ch1_burst", 32'(b_rburst), 32'd3);
    chk("lvl_ch1_beat",  32'(b_rbeat),  32'd3);

    // Selector beyond the channel count reads zero
    b_sel = 2'd3; tick();
    chk("oor_beat",  32'(b_rbeat),  32'd0);
    chk("oor_burst", 32'(b_rburst), 32'd0);
    chk("oor_flags", 32'(b_flags),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bw_monitor_mc.md
Name: bw_monitor_mc

Overview:
Multi-channel, parametrised successor to the single-pair bandwidth tester. Counts qualified beats and bursts on NUM_CH independent stream/AXI channels inside a bounded, software-controlled measurement window. Records first-beat and last-burst timestamps and saturation flags per channel. Sits beside the DMA/stream datapath and is read by the register block through a channel-select read port.

Parameters:
NUM_CH, 4, number of monitored channels (1..16)
CNT_W, 32, width of beat/burst counters (8..64)
TS_W, 32, width of window timer and timestamps (8..64)
LAST_EDGE, 1, 1 = burst counted on rising edge of last; 0 = counted on every beat with last=1
ARM_ON_ACT, 1, 1 = ARMED waits for first beat on any channel; 0 = enters RUN next cycle

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
beat  in  NUM_CH  per-channel qualified beat (valid&ready), bit i = channel i
last  in  NUM_CH  per-channel last marker, bit i = channel i
start  in  1  pulse: clear all statistics and arm window
stop  in  1  pulse: end window early
window_len  in  TS_W  window length in cycles; 0 = unbounded
chan_sel  in  clog2(NUM_CH) (min 1)  channel selected for read port
state  out  2  0 IDLE, 1 ARMED, 2 RUN, 3 DONE
busy  out  1  high in ARMED or RUN
timer  out  TS_W  window timer
timer_ovf  out  1  timer saturated
rd_beat_cnt  out  CNT_W  selected channel beat count
rd_burst_cnt  out  CNT_W  selected channel burst count
rd_first_ts  out  TS_W  timer value at selected channel's first beat
rd_last_ts  out  TS_W  timer value at selected channel's most recent burst end
rd_flags  out  3  {seen, burst_sat, beat_sat} for selected channel

Behaviour:
- rst: state=IDLE; timer=0; timer_ovf=0; every channel counter/timestamp/flag=0; read outputs=0; last-edge delay regs=0.
- Compulsory clear: start in any state other than RUN clears timer, timer_ovf, all channel stats; next state ARMED. start in RUN ignored.
- IDLE: hold; wait for start.
- ARMED: ARM_ON_ACT=0 -> RUN next cycle, nothing counted in ARMED. ARM_ON_ACT=1 -> stay until any beat bit high; that cycle moves to RUN AND that beat is counted with timestamp 0.
- RUN: timer increments by 1 each cycle from 0; saturates at all-ones and sets timer_ovf (sticky until start/rst). Transition to DONE when stop=1, or window_len!=0 and timer==window_len-1; activity in that final cycle is still counted.
- DONE: all statistics frozen; inputs ignored; stays until start or rst.
- Per channel i, only in RUN (or the ARMED->RUN cycle):
  - beat[i]: beat_cnt+1; saturates at all-ones, sets beat_sat (sticky).
  - burst event = LAST_EDGE ? (last[i] & ~last_d[i]) : (beat[i] & last[i]); last_d[i] updates every cycle in all states except reset. On event: burst_cnt+1 (saturating, burst_sat sticky), last_ts=timer.
  - first beat while seen=0: first_ts=timer, seen=1.
  - Channels independent; simultaneous events on several channels all counted same cycle.
- Timestamp = timer value in the same cycle as the event (before increment).
- Read port: rd_* registered, 1-cycle latency from chan_sel; chan_sel>=NUM_CH returns zeros. Reflects live values during RUN.
- start and stop same cycle in RUN: stop wins (DONE). rst overrides everything.

Test Plan:
- ARM_ON_ACT=0, window_len=10, start, beat[0] every cycle, last[0] on each 4th beat -> DONE after 10 RUN cycles; ch0 beat_cnt=10, burst_cnt=2, first_ts=0, last_ts=7; timer=9.
- ARM_ON_ACT=1, start, idle 5 cycles, beat[2]=1 one cycle -> state RUN that cycle; ch2 beat_cnt=1, first_ts=0, seen=1; other channels 0.
- LAST_EDGE=1, last[1] held high 3 cycles with beat -> burst_cnt=1; LAST_EDGE=0 same stimulus -> burst_cnt=3.
- CNT_W=8, window_len=0, beat[3] continuous 300 cycles -> beat_cnt=255, beat_sat=1; stop -> DONE, values frozen despite further beats.
- TS_W=8, window_len=0, run 300 cycles -> timer=255, timer_ovf=1; start from DONE -> all stats 0, state ARMED.
- rst asserted mid-RUN with non-zero counts -> next cycle state=IDLE, all outputs 0; chan_sel=NUM_CH -> rd_* = 0.
